// File: rtl/fastica_ctrl_pkg.sv
// Shared state encoding and default sizing for the FastICA iteration sequencer.
package fastica_ctrl_pkg;

  localparam int unsigned N_MUL_DEF      = 5;
  localparam int unsigned MUL_LAT_DEF    = 4;
  localparam int unsigned N_SAMPLES_DEF  = 128;
  localparam int unsigned MEAN_DRAIN_DEF = 3;
  localparam int unsigned MAX_ITER_DEF   = 16;

  localparam int unsigned PHASE_MAX_DEF =
    (MUL_LAT_DEF > N_SAMPLES_DEF + MEAN_DRAIN_DEF) ? MUL_LAT_DEF
                                                   : N_SAMPLES_DEF + MEAN_DRAIN_DEF;
  localparam int unsigned CNT_W_DEF  = $clog2(PHASE_MAX_DEF + 1);
  localparam int unsigned ITER_W_DEF = $clog2(MAX_ITER_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_MEAN  = 3'd2,
    ST_SUB   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

  // Datapath phases are the only states that hold can stall.
  function automatic logic is_phase(input seq_state_t s);
    return (s == ST_MUL) || (s == ST_MEAN) || (s == ST_SUB);
  endfunction

endpackage

// File: rtl/fastica_iter_seq_if.sv
// Control/status bundle between the FastICA sequencer and its host/datapath.
interface fastica_iter_seq_if
  import fastica_ctrl_pkg::*;
#(
  parameter int unsigned N_MUL  = N_MUL_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned ITER_W = ITER_W_DEF
);
  logic              start;
  logic              hold;
  logic              conv_valid;
  logic              conv_ok;
  logic              fast_busy;
  logic              done;
  logic              converged;
  logic              timeout;
  logic [ITER_W-1:0] iter_cnt;
  logic [CNT_W-1:0]  sample_idx;
  logic              en_b;
  logic [N_MUL-1:0]  en_mul;
  logic              en_mean;
  logic              en_sub;

  modport master (
    output start, hold, conv_valid, conv_ok,
    input  fast_busy, done, converged, timeout, iter_cnt, sample_idx,
           en_b, en_mul, en_mean, en_sub
  );

  modport slave (
    input  start, hold, conv_valid, conv_ok,
    output fast_busy, done, converged, timeout, iter_cnt, sample_idx,
           en_b, en_mul, en_mean, en_sub
  );
endinterface

// File: rtl/fastica_phase_cnt.sv
// Phase cycle counter with synchronous clear, enable and terminal-count compare.
module fastica_phase_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_fast,
  input  logic             go_fast,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             at_term_c
);

  always_ff @(posedge clk_fast or negedge go_fast) begin
    if (!go_fast)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + CNT_W'(1);
  end

  assign at_term_c = (cnt == term);

endmodule

// File: rtl/fastica_iter_seq.sv
// Iteration sequencer: MUL -> MEAN -> SUB -> CHECK per pass until convergence or MAX_ITER.
module fastica_iter_seq
  import fastica_ctrl_pkg::*;
#(
  parameter int unsigned N_MUL      = N_MUL_DEF,
  parameter int unsigned MUL_LAT    = MUL_LAT_DEF,
  parameter int unsigned N_SAMPLES  = N_SAMPLES_DEF,
  parameter int unsigned MEAN_DRAIN = MEAN_DRAIN_DEF,
  parameter int unsigned MAX_ITER   = MAX_ITER_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned ITER_W     = ITER_W_DEF
) (
  input logic               clk_fast,
  input logic               go_fast,
  fastica_iter_seq_if.slave sq
);

  seq_state_t        state_q, state_d;
  logic [ITER_W-1:0] iter_q;
  logic              conv_q, tmo_q;
  logic [CNT_W-1:0]  cnt, term;
  logic              at_term, cnt_en, cnt_clr, run, last_pass;

  assign run       = is_phase(state_q) && !sq.hold;
  assign last_pass = (iter_q == ITER_W'(MAX_ITER - 1));
  assign term      = (state_q == ST_MUL) ? CNT_W'(MUL_LAT - 1)
                                         : CNT_W'(N_SAMPLES + MEAN_DRAIN - 1);

  // Count only in MUL/MEAN; clear on phase exit and whenever outside them.
  assign cnt_en  = run && (state_q != ST_SUB);
  assign cnt_clr = !((state_q == ST_MUL) || (state_q == ST_MEAN)) || (cnt_en && at_term);

  fastica_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk_fast  (clk_fast),
    .go_fast   (go_fast),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .term      (term),
    .cnt       (cnt),
    .at_term_c (at_term)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sq.start)          state_d = ST_MUL;
      ST_MUL:   if (run && at_term)    state_d = ST_MEAN;
      ST_MEAN:  if (run && at_term)    state_d = ST_SUB;
      ST_SUB:   if (run)               state_d = ST_CHECK;
      ST_CHECK: if (sq.conv_valid)     state_d = (sq.conv_ok || last_pass) ? ST_DONE : ST_MUL;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // State, pass index and sticky run-status flags.
  always_ff @(posedge clk_fast or negedge go_fast) begin
    if (!go_fast) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && sq.start) begin
        iter_q <= '0;
        conv_q <= 1'b0;
        tmo_q  <= 1'b0;
      end else if (state_q == ST_CHECK && sq.conv_valid) begin
        if (sq.conv_ok)     conv_q <= 1'b1;
        else if (last_pass) tmo_q  <= 1'b1;
        else                iter_q <= iter_q + ITER_W'(1);
      end
    end
  end

  // Moore decode of the state register, with hold gating the datapath enables.
  assign sq.fast_busy  = (state_q != ST_IDLE);
  assign sq.done       = (state_q == ST_DONE);
  assign sq.converged  = conv_q;
  assign sq.timeout    = tmo_q;
  assign sq.iter_cnt   = iter_q;
  assign sq.en_b       = (state_q == ST_IDLE) || (state_q == ST_CHECK);
  assign sq.en_mul     = run ? '1 : '0;
  assign sq.en_mean    = run && (state_q != ST_MUL);
  assign sq.en_sub     = run && (state_q == ST_SUB);
  assign sq.sample_idx = (state_q != ST_MEAN)         ? '0 :
                         (cnt < CNT_W'(N_SAMPLES))    ? cnt : CNT_W'(N_SAMPLES - 1);

endmodule
